dot_mem_sequencer: RTL and testbench

//  - Job-based SRAM sequencer for the dot-product datapath; succeeds the fixed 3-SRAM, free-running controller.
//  - Nums_Operand operand SRAMs are read in lock-step over a programmable vector length.
//  - One result SRAM receives one word per job; its write pointer auto-increments across jobs.
//  - Drives accumulator control (Acc_Clear/Acc_Valid) aligned to parameterised SRAM read latency; supports stall.

---
 rtl/dotmem_pkg.sv | 22 ++
 rtl/dotmem_valid_pipe.sv | 46 ++++
 rtl/dot_mem_sequencer.sv | 145 ++++++++++++++
 tb/tb_dot_mem_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dotmem_pkg.sv
// Shared types and helpers for the dot-product SRAM sequencer.
package dotmem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 4;
    localparam int unsigned DEF_NUMS_OPERAND = 2;
    localparam int unsigned RESULT_BANK      = DEF_NUMS_OPERAND;
    localparam int unsigned PERF_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bit offset of a bank's slice inside a packed address bus.
    function automatic int unsigned slice_off(input int unsigned bank, input int unsigned aw);
        return bank * aw;
    endfunction

endpackage

// File: rtl/dotmem_valid_pipe.sv
// Read-latency alignment pipe carrying {valid, first} from read issue to
// accumulator control; also reports whether any beat is still in flight.
module dotmem_valid_pipe #(
    parameter int unsigned Read_Latency = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    input  logic first_in,
    output logic acc_valid,
    output logic acc_clear,
    output logic pipe_empty
);

    logic [Read_Latency-1:0] v_q;
    logic [Read_Latency-1:0] f_q;
    logic                    pend;

    // Shift register, stage 0 loads the issue strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            f_q <= '0;
        end else begin
            for (int i = int'(Read_Latency) - 1; i > 0; i--) begin
                v_q[i] <= v_q[i-1];
                f_q[i] <= f_q[i-1];
            end
            v_q[0] <= valid_in;
            f_q[0] <= first_in;
        end
    end

    // Beats still queued behind the output stage.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < int'(Read_Latency) - 1; i++) begin
            pend = pend | v_q[i];
        end
    end

    assign acc_valid  = v_q[Read_Latency-1];
    assign acc_clear  = f_q[Read_Latency-1];
    assign pipe_empty = ~pend;

endmodule

// File: rtl/dot_mem_sequencer.sv
// Job-based SRAM sequencer for the dot-product datapath.
// Optional feature: define DOTMEM_PERF_CNT_EN to build the busy-cycle counter.
module dot_mem_sequencer
    import dotmem_pkg::*;
#(
    parameter int unsigned Addr_Width   = DEF_ADDR_WIDTH,
    parameter int unsigned Ram_Depth    = 16,
    parameter int unsigned Nums_Operand = DEF_NUMS_OPERAND,
    parameter int unsigned Nums_SRAM    = Nums_Operand + 1,
    parameter int unsigned Read_Latency = 1
) (
    input  logic                            clk,
    input  logic                            Mem_reset,
    input  logic                            Start,
    input  logic [Addr_Width:0]             Vec_Len,
    input  logic                            Pause,
    input  logic                            Clear_Req,
    output logic [Nums_SRAM-1:0]            Mem_Clear,
    output logic [Nums_SRAM-1:0]            En_Chip_Select,
    output logic [Nums_SRAM-1:0]            En_Write,
    output logic [Nums_SRAM-1:0]            En_Read,
    output logic [Nums_SRAM*Addr_Width-1:0] Addr_Read,
    output logic [Nums_SRAM*Addr_Width-1:0] Addr_Write,
    output logic                            Acc_Clear,
    output logic                            Acc_Valid,
    output logic                            Busy,
    output logic                            Done,
    output logic [PERF_W-1:0]               Perf_Cycles
);

    state_t                state_q, state_d;
    logic [Addr_Width-1:0] idx_q, len_m1_q, res_ptr_q, wr_addr_q;
    logic                  mem_clear_q;
    logic [Addr_Width:0]   len_clamped;
    logic                  start_ok, clear_ok, issue, pipe_empty;

    // Length clamp and IDLE-only request qualification (clear beats start).
    always_comb begin
        if (Vec_Len > (Addr_Width+1)'(Ram_Depth)) len_clamped = (Addr_Width+1)'(Ram_Depth);
        else                                      len_clamped = Vec_Len;
        clear_ok = (state_q == ST_IDLE) && Clear_Req;
        start_ok = (state_q == ST_IDLE) && Start && !Clear_Req;
        issue    = (state_q == ST_RUN) && !Pause;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (Mem_reset) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next-state and bank strobes.
    always_comb begin
        state_d    = state_q;
        En_Read    = '0;
        En_Write   = '0;
        Addr_Read  = '0;
        Addr_Write = '0;
        Busy       = 1'b0;
        Done       = 1'b0;
        for (int unsigned b = 0; b < Nums_Operand; b++) begin
            En_Read[b]                                   = issue;
            Addr_Read[slice_off(b, Addr_Width) +: Addr_Width] = idx_q;
        end
        Addr_Write[slice_off(Nums_Operand, Addr_Width) +: Addr_Width] = wr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                Busy = 1'b1;
                if (issue && (idx_q == len_m1_q)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                Busy = 1'b1;
                if (pipe_empty) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                Busy                   = 1'b1;
                En_Write[Nums_Operand] = 1'b1;
                Addr_Write[slice_off(Nums_Operand, Addr_Width) +: Addr_Width] = res_ptr_q;
                state_d                = ST_DONE;
            end
            ST_DONE: begin
                Done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Element index, job length, result pointer and clear strobe.
    always_ff @(posedge clk) begin
        if (Mem_reset) begin
            idx_q       <= '0;
            len_m1_q    <= '0;
            res_ptr_q   <= '0;
            wr_addr_q   <= '0;
            mem_clear_q <= 1'b0;
        end else begin
            mem_clear_q <= clear_ok;
            if (start_ok) len_m1_q <= Addr_Width'(len_clamped - (Addr_Width+1)'(1));
            if (start_ok && (len_clamped != '0))      idx_q <= '0;
            else if (issue && (idx_q != len_m1_q))    idx_q <= idx_q + Addr_Width'(1);
            if (clear_ok) begin
                res_ptr_q <= '0;
            end else if (state_q == ST_WRITE) begin
                res_ptr_q <= res_ptr_q + Addr_Width'(1);
                wr_addr_q <= res_ptr_q;
            end
        end
    end

    assign Mem_Clear      = {Nums_SRAM{mem_clear_q}};
    assign En_Chip_Select = Mem_Clear | En_Read | En_Write;

    // Accumulator control aligned to SRAM read latency.
    dotmem_valid_pipe #(
        .Read_Latency (Read_Latency)
    ) u_valid_pipe (
        .clk        (clk),
        .rst        (Mem_reset),
        .valid_in   (issue),
        .first_in   (issue && (idx_q == '0)),
        .acc_valid  (Acc_Valid),
        .acc_clear  (Acc_Clear),
        .pipe_empty (pipe_empty)
    );

`ifdef DOTMEM_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q;

    // Saturating busy-cycle counter, restarted by each accepted job.
    always_ff @(posedge clk) begin
        if (Mem_reset)                              perf_q <= '0;
        else if (start_ok)                          perf_q <= '0;
        else if (Busy && (perf_q != {PERF_W{1'b1}})) perf_q <= perf_q + PERF_W'(1);
    end

    assign Perf_Cycles = perf_q;
`else
    assign Perf_Cycles = '0;
`endif

endmodule

// File: tb/tb_dot_mem_sequencer.sv
// Directed bench for dot_mem_sequencer (Read_Latency 1 and 3 instances).
module tb_dot_mem_sequencer;

    logic        clk = 1'b0;
    logic        mem_reset, start, pause, clear_req;
    logic [4:0]  vec_len;

    logic [2:0]  mem_clear, cs, en_write, en_read;
    logic [11:0] addr_read, addr_write;
    logic        acc_clear, acc_valid, busy, done;
    logic [15:0] perf;

    logic [2:0]  mem_clear_3, cs_3, en_write_3, en_read_3;
    logic [11:0] addr_read_3, addr_write_3;
    logic        acc_clear_3, acc_valid_3, busy_3, done_3;
    logic [15:0] perf_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_mem_sequencer u_dut (
        .clk(clk), .Mem_reset(mem_reset), .Start(start), .Vec_Len(vec_len),
        .Pause(pause), .Clear_Req(clear_req), .Mem_Clear(mem_clear),
        .En_Chip_Select(cs), .En_Write(en_write), .En_Read(en_read),
        .Addr_Read(addr_read), .Addr_Write(addr_write), .Acc_Clear(acc_clear),
        .Acc_Valid(acc_valid), .Busy(busy), .Done(done), .Perf_Cycles(perf)
    );

    dot_mem_sequencer #(.Read_Latency(3)) u_dut3 (
        .clk(clk), .Mem_reset(mem_reset), .Start(start), .Vec_Len(vec_len),
        .Pause(pause), .Clear_Req(clear_req), .Mem_Clear(mem_clear_3),
        .En_Chip_Select(cs_3), .En_Write(en_write_3), .En_Read(en_read_3),
        .Addr_Read(addr_read_3), .Addr_Write(addr_write_3), .Acc_Clear(acc_clear_3),
        .Acc_Valid(acc_valid_3), .Busy(busy_3), .Done(done_3), .Perf_Cycles(perf_3)
    );

    typedef struct {
        logic        start;
        logic        pause;
        logic [4:0]  len;
        logic [2:0]  er;
        logic [3:0]  ra;
        logic        av;
        logic        ac;
        logic [2:0]  ew;
        logic [3:0]  wa;
        logic        bsy;
        logic        dn;
        logic [15:0] pf;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic p, input logic [4:0] l,
                                input logic [2:0] er, input logic [3:0] ra,
                                input logic av, input logic ac, input logic [2:0] ew,
                                input logic [3:0] wa, input logic bsy, input logic dn,
                                input logic [15:0] pf);
        vec_t v;
        v.start = s; v.pause = p; v.len = l; v.er = er; v.ra = ra; v.av = av;
        v.ac = ac; v.ew = ew; v.wa = wa; v.bsy = bsy; v.dn = dn; v.pf = pf;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [15:0] perf_exp(input logic [15:0] v);
`ifdef DOTMEM_PERF_CNT_EN
        return v;
`else
        return (v & 16'h0);
`endif
    endfunction

    vec_t tbl[19];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  reads, got, cyc;
        logic [3:0] last_ra;

        // Len=4 job then paused Len=4 job (Read_Latency 1).
        tbl[0]  = mk(1,0,4, 3'b000,0,0,0, 3'b000,0,0,0, 0);
        tbl[1]  = mk(0,0,4, 3'b011,0,0,0, 3'b000,0,1,0, 0);
        tbl[2]  = mk(0,0,4, 3'b011,1,1,1, 3'b000,0,1,0, 1);
        tbl[3]  = mk(0,0,4, 3'b011,2,1,0, 3'b000,0,1,0, 2);
        tbl[4]  = mk(0,0,4, 3'b011,3,1,0, 3'b000,0,1,0, 3);
        tbl[5]  = mk(0,0,4, 3'b000,3,1,0, 3'b000,0,1,0, 4);
        tbl[6]  = mk(0,0,4, 3'b000,3,0,0, 3'b100,0,1,0, 5);
        tbl[7]  = mk(0,0,4, 3'b000,3,0,0, 3'b000,0,0,1, 6);
        tbl[8]  = mk(0,0,4, 3'b000,3,0,0, 3'b000,0,0,0, 6);
        tbl[9]  = mk(1,0,4, 3'b000,3,0,0, 3'b000,0,0,0, 6);
        tbl[10] = mk(0,0,4, 3'b011,0,0,0, 3'b000,0,1,0, 0);
        tbl[11] = mk(0,1,4, 3'b000,1,1,1, 3'b000,0,1,0, 1);
        tbl[12] = mk(0,1,4, 3'b000,1,0,0, 3'b000,0,1,0, 2);
        tbl[13] = mk(0,0,4, 3'b011,1,0,0, 3'b000,0,1,0, 3);
        tbl[14] = mk(0,0,4, 3'b011,2,1,0, 3'b000,0,1,0, 4);
        tbl[15] = mk(0,0,4, 3'b011,3,1,0, 3'b000,0,1,0, 5);
        tbl[16] = mk(0,0,4, 3'b000,3,1,0, 3'b000,0,1,0, 6);
        tbl[17] = mk(0,0,4, 3'b000,3,0,0, 3'b100,1,1,0, 7);
        tbl[18] = mk(0,0,4, 3'b000,3,0,0, 3'b000,1,0,1, 8);

        mem_reset = 1'b1; start = 1'b0; pause = 1'b0; clear_req = 1'b0; vec_len = '0;
        repeat (3) nxt();
        smp();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cs", 32'(cs), 0);
        check("rst_addr_rd", 32'(addr_read), 0);
        check("rst_addr_wr", 32'(addr_write), 0);
        check("rst_acc", 32'({acc_valid, acc_clear}), 0);
        check("rst_perf", 32'(perf), 0);
        nxt();
        mem_reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            nxt();
            start = tbl[i].start; pause = tbl[i].pause; vec_len = tbl[i].len;
            smp();
            check($sformatf("row%0d_en_read", i), 32'(en_read), 32'(tbl[i].er));
            check($sformatf("row%0d_addr_read", i), 32'(addr_read), 32'({4'h0, tbl[i].ra, tbl[i].ra}));
            check($sformatf("row%0d_acc_valid", i), 32'(acc_valid), 32'(tbl[i].av));
            check($sformatf("row%0d_acc_clear", i), 32'(acc_clear), 32'(tbl[i].ac));
            check($sformatf("row%0d_en_write", i), 32'(en_write), 32'(tbl[i].ew));
            check($sformatf("row%0d_addr_write", i), 32'(addr_write), 32'({tbl[i].wa, 8'h00}));
            check($sformatf("row%0d_cs", i), 32'(cs), 32'(tbl[i].er | tbl[i].ew));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            check($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].dn));
            check($sformatf("row%0d_mem_clear", i), 32'(mem_clear), 0);
            check($sformatf("row%0d_perf", i), 32'(perf), 32'(perf_exp(tbl[i].pf)));
        end
        nxt();
        start = 1'b0; pause = 1'b0;

        // Clear_Req together with Start: clear wins, job dropped.
        start = 1'b1; clear_req = 1'b1; vec_len = 5'd4;
        smp();
        nxt();
        start = 1'b0; clear_req = 1'b0;
        smp();
        check("clr_mem_clear", 32'(mem_clear), 32'h7);
        check("clr_cs", 32'(cs), 32'h7);
        check("clr_busy", 32'(busy), 0);
        nxt();
        smp();
        check("clr_mem_clear_off", 32'(mem_clear), 0);
        check("clr_no_job", 32'({busy, en_read}), 0);

        // 17 back-to-back Len=1 jobs: result pointer wraps.
        for (int j = 0; j < 17; j++) begin
            nxt();
            start = 1'b1; vec_len = 5'd1;
            smp();
            nxt();
            start = 1'b0;
            got = 0;
            for (int n = 0; n < 20; n++) begin
                smp();
                if (en_write[2]) begin
                    check($sformatf("wrap%0d_addr", j), 32'(addr_write[11:8]), 32'(j % 16));
                    got = 1;
                    break;
                end
                nxt();
            end
            check($sformatf("wrap%0d_write_seen", j), 32'(got), 1);
            got = 0;
            for (int n = 0; n < 10; n++) begin
                nxt();
                smp();
                if (done) begin got = 1; break; end
            end
            check($sformatf("wrap%0d_done_seen", j), 32'(got), 1);
        end

        // Len=0: Done next cycle, no enables.
        nxt();
        start = 1'b1; vec_len = 5'd0;
        smp();
        nxt();
        start = 1'b0;
        smp();
        check("len0_done", 32'(done), 1);
        check("len0_busy", 32'(busy), 0);
        check("len0_cs", 32'(cs), 0);
        nxt();
        smp();
        check("len0_done_off", 32'(done), 0);

        // Len=31 clamps to 16 reads; a Start mid-job is ignored.
        nxt();
        start = 1'b1; vec_len = 5'd31;
        smp();
        nxt();
        start = 1'b0;
        reads = 0; got = 0; last_ra = '0;
        for (int n = 0; n < 60; n++) begin
            smp();
            if (en_read[0]) begin reads++; last_ra = addr_read[3:0]; end
            if (en_write[2]) check("len31_wr_addr", 32'(addr_write[11:8]), 1);
            if (done) begin got = 1; break; end
            nxt();
            start = (n == 3) ? 1'b1 : 1'b0;
        end
        check("len31_done_seen", 32'(got), 1);
        check("len31_reads", 32'(reads), 16);
        check("len31_last_addr", 32'(last_ra), 15);
        nxt();
        start = 1'b0;
        smp();
        check("busy_start_ignored", 32'(busy), 0);

        // Mem_reset in RUN cycle 2 aborts the job.
        nxt();
        start = 1'b1; vec_len = 5'd4;
        smp();
        nxt();
        start = 1'b0;
        smp();
        nxt();
        mem_reset = 1'b1;
        smp();
        nxt();
        mem_reset = 1'b0;
        smp();
        check("abort_busy", 32'(busy), 0);
        check("abort_cs", 32'(cs), 0);
        check("abort_addr", 32'(addr_read), 0);
        check("abort_acc", 32'(acc_valid), 0);
        got = 0;
        for (int n = 0; n < 10; n++) begin
            nxt();
            smp();
            if (en_write[2] || done) got = 1;
        end
        check("abort_no_write_done", 32'(got), 0);

        // Next job after reset writes result address 0.
        nxt();
        start = 1'b1; vec_len = 5'd1;
        smp();
        nxt();
        start = 1'b0;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            smp();
            if (en_write[2]) begin
                check("post_rst_addr", 32'(addr_write[11:8]), 0);
                got = 1;
                break;
            end
            nxt();
        end
        check("post_rst_write_seen", 32'(got), 1);
        repeat (10) nxt();

        // Read_Latency=3, Len=2: write 6 cycles after Start.
        start = 1'b1; vec_len = 5'd2;
        smp();
        nxt();
        start = 1'b0;
        got = 0;
        for (cyc = 1; cyc < 15; cyc++) begin
            smp();
            if (cyc == 4) check("lat3_acc_clear", 32'({acc_valid_3, acc_clear_3}), 32'h3);
            if (en_write_3[2]) begin got = 1; break; end
            nxt();
        end
        check("lat3_write_seen", 32'(got), 1);
        check("lat3_write_cycle", 32'(cyc), 6);
        check("lat3_addr_write", 32'(addr_write_3), 32'h100);
        check("lat3_cs", 32'(cs_3), 32'h4);
        check("lat3_idle_strobes", 32'({mem_clear_3, en_read_3, acc_valid_3, acc_clear_3, done_3}), 0);
        check("lat3_busy", 32'(busy_3), 1);
        check("lat3_addr_read", 32'(addr_read_3), 32'h011);
        check("lat3_perf", 32'(perf_3), 32'(perf_exp(16'd5)));
        nxt();
        smp();
        check("lat3_done", 32'(done_3), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
